// File: rtl/aes_pkg.sv
// Shared types, FSM states and GF(2^8) helpers for the AES-128 key schedule.
// AES_KEY_SCHED_SBOX_PIPE_EN adds the SUB state used by the pipelined SubWord build.
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_key_t;

  typedef enum logic [1:0] {
    IDLE,
    EMIT
`ifdef AES_KEY_SCHED_SBOX_PIPE_EN
    , SUB
`endif
  } key_sched_state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES S-box built on GF((2^4)^2): map to the composite field, invert there, map back, affine.
// The basis-change matrices are derived at elaboration time from the field definitions.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  // Composite field: GF(2^4) mod x^4+x+1, extension x^2+x+LAMBDA (trace of LAMBDA is 1).
  localparam logic [3:0] LAMBDA = 4'hc;

  function automatic logic [7:0] gf8_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p ^= t;
      t = xtime(t);
    end
    return p;
  endfunction

  function automatic logic [7:0] lin_map(input logic [63:0] m, input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (v[i]) r ^= m[8*i +: 8];
    return r;
  endfunction

  // Entry i is the GF(2^8) image of composite-field bit i: bits 3..0 are w^i, bits 7..4 are w^i*X.
  function automatic logic [63:0] basis_to_gf8();
    logic [7:0]  w, x, lam, p;
    logic [63:0] m;
    w   = '0;
    x   = '0;
    lam = '0;
    m   = '0;
    for (int c = 2; c < 256; c++) begin
      p = 8'(c);
      if (w == 8'h00 && (gf8_mul(gf8_mul(p, p), gf8_mul(p, p)) ^ p ^ 8'h01) == 8'h00) w = p;
    end
    p = 8'h01;
    for (int i = 0; i < 4; i++) begin
      if (LAMBDA[i]) lam ^= p;
      m[8*i +: 8] = p;
      p = gf8_mul(p, w);
    end
    for (int c = 2; c < 256; c++) begin
      p = 8'(c);
      if (x == 8'h00 && (gf8_mul(p, p) ^ p ^ lam) == 8'h00) x = p;
    end
    for (int i = 0; i < 4; i++) m[8*(i+4) +: 8] = gf8_mul(m[8*i +: 8], x);
    return m;
  endfunction

  function automatic logic [63:0] invert_map(input logic [63:0] m);
    logic [63:0] inv;
    logic [7:0]  v;
    inv = '0;
    for (int c = 1; c < 256; c++) begin
      v = lin_map(m, 8'(c));
      for (int j = 0; j < 8; j++) if (v == 8'(1 << j)) inv[8*j +: 8] = 8'(c);
    end
    return inv;
  endfunction

  localparam logic [63:0] TO_GF8 = basis_to_gf8();
  localparam logic [63:0] TO_CF  = invert_map(TO_GF8);

  function automatic logic [3:0] gf4_mul(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] p;
    logic [3:0] t;
    p = '0;
    t = x;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) p ^= t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  // x^14 = x^-1 in GF(2^4); zero maps to zero as AES requires.
  function automatic logic [3:0] gf4_inv(input logic [3:0] x);
    logic [3:0] x2, x4, x8;
    x2 = gf4_mul(x, x);
    x4 = gf4_mul(x2, x2);
    x8 = gf4_mul(x4, x4);
    return gf4_mul(gf4_mul(x8, x4), x2);
  endfunction

  logic [7:0] cf, inv;
  logic [3:0] ah, al, d, d_inv;

  always_comb begin
    cf    = lin_map(TO_CF, a);
    ah    = cf[7:4];
    al    = cf[3:0];
    d     = gf4_mul(gf4_mul(ah, ah), LAMBDA) ^ gf4_mul(ah, al) ^ gf4_mul(al, al);
    d_inv = gf4_inv(d);
    inv   = lin_map(TO_GF8, {gf4_mul(ah, d_inv), gf4_mul(ah ^ al, d_inv)});
    s     = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_sched.sv
// Sequential AES-128 key schedule: emits round keys 0..10 over a valid/ready handshake.
// AES_KEY_SCHED_SBOX_PIPE_EN registers SubWord and spends a SUB cycle between keys.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [127:0] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done
);

  if (NR != 10) begin : g_nr_check
    $error("aes_key_sched supports only NR = 10 (AES-128)");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  key_sched_state_e state_q, state_d;
  aes_key_t         rk_d;
  logic [3:0]       round_d;
  logic [7:0]       rcon_q, rcon_d;
  logic             done_d;
  logic             xfer;
  aes_word_t        w3_rot, sub_word;

  function automatic aes_key_t next_key(input aes_key_t k, input aes_word_t sub,
                                        input logic [7:0] rcon);
    aes_word_t t, w0, w1, w2, w3;
    t  = sub ^ {rcon, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign w3_rot = {rk[23:0], rk[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .a(w3_rot[8*b +: 8]),
      .s(sub_word[8*b +: 8])
    );
  end

  assign rk_valid = (state_q == EMIT);
  assign busy     = (state_q != IDLE);
  assign xfer     = rk_valid && rk_ready;

`ifdef AES_KEY_SCHED_SBOX_PIPE_EN
  aes_word_t sub_q, sub_d;
`endif

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    rk_d    = rk;
    round_d = rk_round;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
`ifdef AES_KEY_SCHED_SBOX_PIPE_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (ld) begin
          rk_d    = key;
          round_d = '0;
          rcon_d  = RCON_INIT;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (xfer) begin
          if (rk_round == LAST_ROUND) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
`ifdef AES_KEY_SCHED_SBOX_PIPE_EN
            sub_d   = sub_word;
            state_d = SUB;
`else
            rk_d    = next_key(rk, sub_word, rcon_q);
            round_d = rk_round + 4'd1;
            rcon_d  = xtime(rcon_q);
`endif
          end
        end
      end
`ifdef AES_KEY_SCHED_SBOX_PIPE_EN
      SUB: begin
        rk_d    = next_key(rk, sub_q, rcon_q);
        round_d = rk_round + 4'd1;
        rcon_d  = xtime(rcon_q);
        state_d = EMIT;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rk       <= '0;
      rk_round <= '0;
      rcon_q   <= RCON_INIT;
      done     <= 1'b0;
`ifdef AES_KEY_SCHED_SBOX_PIPE_EN
      sub_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rk       <= rk_d;
      rk_round <= round_d;
      rcon_q   <= rcon_d;
      done     <= done_d;
`ifdef AES_KEY_SCHED_SBOX_PIPE_EN
      sub_q    <= sub_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// Scoreboard bench for aes_key_sched: a behavioural key expansion (brute-force S-box) feeds
// an expected-key queue that is popped on every rk handshake.
module tb_aes_key_sched;
  import aes_pkg::*;

`ifdef AES_KEY_SCHED_SBOX_PIPE_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  localparam aes_key_t FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam aes_key_t FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam aes_key_t FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam aes_key_t ZERO_R1  = 128'h62636363626363636263636362636363;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ld = 1'b0;
  logic       rk_ready = 1'b0;
  aes_key_t   key = '0;
  logic       rk_valid, busy, done;
  aes_key_t   rk;
  logic [3:0] rk_round;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] round;
    aes_key_t   k;
  } exp_t;

  exp_t     exp_q[$];
  aes_key_t got_keys[11];
  aes_key_t last_exp;

  aes_key_sched #(.NR(10)) dut (
    .clk(clk), .rst(rst), .ld(ld), .key(key),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk), .rk_round(rk_round),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= t;
      t = t[7] ? ({t[6:0], 1'b0} ^ 8'h1b) : {t[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] s;
    inv = '0;
    for (int i = 1; i < 256; i++) if (m_mul(b, 8'(i)) == 8'h01) inv = 8'(i);
    s = 8'h63;
    for (int i = 0; i < 8; i++)
      s[i] = s[i] ^ inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
    return s;
  endfunction

  task automatic push_schedule(input aes_key_t k);
    logic [31:0] w[4];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    exp_q.push_back('{4'd0, k});
    for (int r = 1; r <= 10; r++) begin
      t = {m_sbox(w[3][23:16]), m_sbox(w[3][15:8]), m_sbox(w[3][7:0]), m_sbox(w[3][31:24])}
          ^ {rc, 24'h0};
      w[0] = w[0] ^ t;
      w[1] = w[1] ^ w[0];
      w[2] = w[2] ^ w[1];
      w[3] = w[3] ^ w[2];
      exp_q.push_back('{4'(r), {w[0], w[1], w[2], w[3]}});
      rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
    end
    last_exp = {w[0], w[1], w[2], w[3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads k, then drains the schedule while optionally stalling and pulsing ld with other_key.
  task automatic run_sched(input aes_key_t k, input int stall_at, input int stall_len,
                           input logic [10:0] ld_mask, input aes_key_t other_key);
    int   cyc, stalls;
    logic seen_done, prev_mid, ready;
    exp_t e;
    push_schedule(k);
    key = k;
    ld = 1'b1;
    rk_ready = 1'b1;
    tick();
    ld = 1'b0;
    cyc = 1;
    stalls = 0;
    seen_done = 1'b0;
    prev_mid = 1'b0;
    checks++;
    if (rk_valid !== 1'b1) begin
      errors++;
      $display("FAIL load_latency: rk_valid=%b expected 1", rk_valid);
    end
    while (!seen_done && cyc < 80) begin
      if (done === 1'b1) begin
        seen_done = 1'b1;
        checks++;
        if (cyc != 10*STEP + 2 + stall_len || rk_valid !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL done_timing: cycle=%0d valid=%b busy=%b expected cycle=%0d valid=0 busy=0",
                   cyc, rk_valid, busy, 10*STEP + 2 + stall_len);
        end
      end else begin
        if (prev_mid) begin
          checks++;
          if (rk_valid !== (STEP == 1)) begin
            errors++;
            $display("FAIL valid_cadence: rk_valid=%b expected %b", rk_valid, STEP == 1);
          end
        end
        prev_mid = 1'b0;
        ready = 1'b1;
        ld = 1'b0;
        key = k;
        if (rk_valid === 1'b1) begin
          if (int'(rk_round) == stall_at && stalls < stall_len) begin
            ready = 1'b0;
            stalls++;
            checks++;
            if (exp_q.size() == 0 || rk !== exp_q[0].k || rk_round !== exp_q[0].round) begin
              errors++;
              $display("FAIL stall_hold: rk=%h round=%0d not held", rk, rk_round);
            end
          end
          if (rk_round <= 4'd10 && ld_mask[rk_round]) begin
            ld = 1'b1;
            key = other_key;
          end
          if (ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL scoreboard_empty: unexpected rk=%h round=%0d", rk, rk_round);
            end else begin
              e = exp_q.pop_front();
              if (rk !== e.k || rk_round !== e.round) begin
                errors++;
                $display("FAIL round_key: got round %0d key %h expected round %0d key %h",
                         rk_round, rk, e.round, e.k);
              end
              got_keys[e.round] = rk;
              prev_mid = (e.round != 4'd10);
            end
          end
        end
        rk_ready = ready;
        tick();
        cyc++;
      end
    end
    ld = 1'b0;
    if (!seen_done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: %0d keys not emitted, expected 0", exp_q.size());
      exp_q.delete();
    end
    tick();
    checks++;
    if (done !== 1'b0 || rk_valid !== 1'b0 || rk !== last_exp) begin
      errors++;
      $display("FAIL after_done: done=%b valid=%b rk=%h expected done=0 valid=0 rk=%h",
               done, rk_valid, rk, last_exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rk !== '0 || rk_round !== 4'd0) begin
      errors++;
      $display("FAIL reset_values: valid=%b busy=%b done=%b rk=%h round=%0d expected all 0",
               rk_valid, busy, done, rk, rk_round);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fips();
    run_sched(FIPS_KEY, -1, 0, 11'b0, '0);
    checks++;
    if (got_keys[0] !== FIPS_KEY || got_keys[1] !== FIPS_R1 || got_keys[10] !== FIPS_R10) begin
      errors++;
      $display("FAIL fips_vector: r0=%h r1=%h r10=%h expected %h %h %h",
               got_keys[0], got_keys[1], got_keys[10], FIPS_KEY, FIPS_R1, FIPS_R10);
    end
  endtask

  task automatic test_backpressure();
    run_sched(FIPS_KEY, 4, 3, 11'b0, '0);
    checks++;
    if (got_keys[10] !== FIPS_R10) begin
      errors++;
      $display("FAIL backpressure_final: r10=%h expected %h", got_keys[10], FIPS_R10);
    end
  endtask

  task automatic test_ld_ignored();
    run_sched(FIPS_KEY, -1, 0, 11'b100_0000_0100, 128'h00112233445566778899aabbccddeeff);
    checks++;
    if (got_keys[1] !== FIPS_R1 || got_keys[10] !== FIPS_R10) begin
      errors++;
      $display("FAIL ld_ignored: r1=%h r10=%h expected %h %h",
               got_keys[1], got_keys[10], FIPS_R1, FIPS_R10);
    end
  endtask

  task automatic test_zero_key();
    run_sched('0, -1, 0, 11'b0, '0);
    checks++;
    if (got_keys[1] !== ZERO_R1) begin
      errors++;
      $display("FAIL zero_key_r1: got %h expected %h", got_keys[1], ZERO_R1);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    key = FIPS_KEY;
    ld = 1'b1;
    rk_ready = 1'b1;
    tick();
    ld = 1'b0;
    n = 0;
    while (!(rk_valid === 1'b1 && rk_round == 4'd6) && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (rk_round !== 4'd6) begin
      errors++;
      $display("FAIL reach_round6: round=%0d expected 6", rk_round);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rk !== '0 || rk_round !== 4'd0) begin
      errors++;
      $display("FAIL async_abort: valid=%b busy=%b done=%b rk=%h round=%0d expected all 0",
               rk_valid, busy, done, rk, rk_round);
    end
    tick();
    checks++;
    if (done !== 1'b0 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done=%b valid=%b expected 0 0", done, rk_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    run_sched(FIPS_KEY, -1, 0, 11'b0, '0);
    checks++;
    if (got_keys[0] !== FIPS_KEY || got_keys[1] !== FIPS_R1) begin
      errors++;
      $display("FAIL restart_after_reset: r0=%h r1=%h expected %h %h",
               got_keys[0], got_keys[1], FIPS_KEY, FIPS_R1);
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_backpressure();
    test_ld_ignored();
    test_zero_key();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
